router_fsm: RTL



---
 rtl/router_pkg.sv | 47 ++++
 rtl/router_fsm.sv | 139 +++++++++++++
 2 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: default sizing, FSM state encoding and the
// control-strobe bundle driven by the packet-sequencing controller.
package router_pkg;

    localparam int unsigned DEF_NUM_PORTS = 3;
    localparam int unsigned DEF_ADDR_W    = 2;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    // Control strobes towards the register block, synchronizer and source
    typedef struct packed {
        logic detect_add;
        logic lfd_state;
        logic ld_state;
        logic laf_state;
        logic full_state;
        logic write_enb_reg;
        logic rst_int_reg;
        logic busy;
    } ctrl_t;

    // Moore decode: strobes are a pure function of the state
    function automatic ctrl_t decode_ctrl(input state_t st);
        ctrl_t c;
        c               = '0;
        c.detect_add    = (st == DECODE_ADDRESS);
        c.lfd_state     = (st == LOAD_FIRST_DATA);
        c.ld_state      = (st == LOAD_DATA);
        c.laf_state     = (st == LOAD_AFTER_FULL);
        c.full_state    = (st == FIFO_FULL_STATE);
        c.rst_int_reg   = (st == CHECK_PARITY_ERROR);
        c.write_enb_reg = (st == LOAD_DATA) || (st == LOAD_PARITY) ||
                          (st == LOAD_AFTER_FULL);
        c.busy          = !((st == DECODE_ADDRESS) || (st == LOAD_DATA));
        return c;
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router.
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   pkt_valid, din  - input byte qualifier and header address field
//   fifo_full       - full flag of the addressed FIFO
//   fifo_empty      - per-FIFO empty flags
//   soft_reset      - per-FIFO timeout soft reset
//   parity_done     - register block latched the parity byte
//   low_pkt_valid   - register block saw pkt_valid fall while stalled
//   detect_add, lfd_state, ld_state, laf_state, full_state,
//   write_enb_reg, rst_int_reg, busy - registered Moore strobes
module router_fsm
    import router_pkg::*;
#(
    parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
    parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    din,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 write_enb_reg,
    output logic                 rst_int_reg,
    output logic                 busy
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    ctrl_t               ctrl_q, ctrl_d;

    logic hdr_ok;
    logic hdr_empty;
    logic addr_empty;
    logic addr_srst;

    // State, address and strobe registers; strobes are registered from the
    // next state so they line up with the state they decode
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
            ctrl_q  <= decode_ctrl(DECODE_ADDRESS);
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Next-state, address capture and strobe decode
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        hdr_empty  = 1'b0;
        addr_empty = 1'b0;
        addr_srst  = 1'b0;

        // Out-of-range addresses select nothing rather than indexing past the vectors
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (din == ADDR_W'(i)) begin
                hdr_empty = fifo_empty[i];
            end
            if (addr_q == ADDR_W'(i)) begin
                addr_empty = fifo_empty[i];
                addr_srst  = soft_reset[i];
            end
        end

        hdr_ok = pkt_valid && (32'(din) < NUM_PORTS);

        unique case (state_q)
            DECODE_ADDRESS: begin
                if (hdr_ok) begin
                    addr_d  = din;
                    state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full) begin
                    state_d = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    state_d = LOAD_PARITY;
                end
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    state_d = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    state_d = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    state_d = LOAD_PARITY;
                end else begin
                    state_d = LOAD_DATA;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (addr_empty) begin
                    state_d = LOAD_FIRST_DATA;
                end
            end
            default: state_d = DECODE_ADDRESS;
        endcase

        // Timeout on the active FIFO abandons the packet; header decode is immune
        if ((state_q != DECODE_ADDRESS) && addr_srst) begin
            state_d = DECODE_ADDRESS;
        end

        ctrl_d = decode_ctrl(state_d);
    end

    assign detect_add    = ctrl_q.detect_add;
    assign lfd_state     = ctrl_q.lfd_state;
    assign ld_state      = ctrl_q.ld_state;
    assign laf_state     = ctrl_q.laf_state;
    assign full_state    = ctrl_q.full_state;
    assign write_enb_reg = ctrl_q.write_enb_reg;
    assign rst_int_reg   = ctrl_q.rst_int_reg;
    assign busy          = ctrl_q.busy;

endmodule
